// File: rtl/knap_search.sv
// Gray-code enumerator for 0/1 multi-constraint knapsack: walks one selection
// per cycle with incrementally updated totals and stops at the first feasible one.
module knap_search #(
   parameter int N_ITEMS = 22,
   parameter int W       = 9,
   parameter int AW      = 5,
   parameter int ACC_W   = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               item_we,
   input  logic [AW-1:0]      item_addr,
   input  logic [W-1:0]       item_value,
   input  logic [W-1:0]       item_weight,
   input  logic [W-1:0]       item_volume,
   input  logic [W-1:0]       min_value,
   input  logic [W-1:0]       max_weight,
   input  logic [W-1:0]       max_volume,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [N_ITEMS-1:0] solution,
   output logic [ACC_W-1:0]   sol_value,
   output logic [ACC_W-1:0]   sol_weight,
   output logic [ACC_W-1:0]   sol_volume
);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   localparam logic [N_ITEMS-1:0] J_LAST = '1;
   localparam logic [N_ITEMS-1:0] ONE    = N_ITEMS'(1);

   state_t state, state_next;

   logic [W-1:0]       value_tab  [N_ITEMS];
   logic [W-1:0]       weight_tab [N_ITEMS];
   logic [W-1:0]       volume_tab [N_ITEMS];

   logic [W-1:0]       lat_min, lat_weight, lat_volume;
   logic [N_ITEMS-1:0] cand, j, j_next, flip_mask;
   logic [ACC_W-1:0]   acc_value, acc_weight, acc_volume;
   logic [W-1:0]       d_value, d_weight, d_volume;
   logic               flip_up, all_pass;

   assign busy = (state == SEARCH);
   assign done = (state == DONE);

   // The bit flipped between gray(j) and gray(j+1) is the lowest set bit of j+1;
   // its item entry is the delta applied to the running totals.
   always_comb begin
      j_next    = j + ONE;
      flip_mask = j_next & ~(j_next - ONE);
      flip_up   = |(flip_mask & ~cand);
      d_value   = '0;
      d_weight  = '0;
      d_volume  = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (flip_mask[i]) begin
            d_value  = value_tab[i];
            d_weight = weight_tab[i];
            d_volume = volume_tab[i];
         end
      end
      all_pass = (acc_value  >= ACC_W'(lat_min))    &&
                 (acc_weight <= ACC_W'(lat_weight)) &&
                 (acc_volume <= ACC_W'(lat_volume));
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SEARCH;
         SEARCH:  if (all_pass || (j == J_LAST)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Item table: writes outside the table range or during a search are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            value_tab[i]  <= '0;
            weight_tab[i] <= '0;
            volume_tab[i] <= '0;
         end
      end else if (item_we && (state != SEARCH)) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            if (item_addr == AW'(i)) begin
               value_tab[i]  <= item_value;
               weight_tab[i] <= item_weight;
               volume_tab[i] <= item_volume;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_min    <= '0;
         lat_weight <= '0;
         lat_volume <= '0;
         cand       <= '0;
         j          <= '0;
         acc_value  <= '0;
         acc_weight <= '0;
         acc_volume <= '0;
         found      <= 1'b0;
         solution   <= '0;
         sol_value  <= '0;
         sol_weight <= '0;
         sol_volume <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lat_min    <= min_value;
                  lat_weight <= max_weight;
                  lat_volume <= max_volume;
                  cand       <= '0;
                  j          <= '0;
                  acc_value  <= '0;
                  acc_weight <= '0;
                  acc_volume <= '0;
                  found      <= 1'b0;
                  solution   <= '0;
                  sol_value  <= '0;
                  sol_weight <= '0;
                  sol_volume <= '0;
               end
            end
            SEARCH: begin
               if (all_pass) begin
                  found      <= 1'b1;
                  solution   <= cand;
                  sol_value  <= acc_value;
                  sol_weight <= acc_weight;
                  sol_volume <= acc_volume;
               end else if (j != J_LAST) begin
                  j    <= j_next;
                  cand <= cand ^ flip_mask;
                  if (flip_up) begin
                     acc_value  <= acc_value  + ACC_W'(d_value);
                     acc_weight <= acc_weight + ACC_W'(d_weight);
                     acc_volume <= acc_volume + ACC_W'(d_volume);
                  end else begin
                     acc_value  <= acc_value  - ACC_W'(d_value);
                     acc_weight <= acc_weight - ACC_W'(d_weight);
                     acc_volume <= acc_volume - ACC_W'(d_volume);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/knap_search.md
# knap_search

Sequential search engine for the 0/1 multi-constraint knapsack instances handled by the combinational `*_multi` validity checkers. The block holds a loadable item table (value, weight, volume per item) and, on `start`, enumerates item selections in Gray-code order at one candidate per cycle. It updates running totals incrementally and stops at the first selection meeting all three constraints. It is the producer side of the checker: it emits a selection vector that a checker instance asserts `valid` on, or reports that no such selection exists.

## Interface
- `N_ITEMS`, 22, number of items (selection bits); legal range 2..24.
- `W`, 9, width of per-item value/weight/volume and of the constraint inputs.
- `AW`, 5, item address width; must satisfy 2^AW >= N_ITEMS.
- `ACC_W`, 14, accumulator width; must satisfy ACC_W >= W + ceil(log2(N_ITEMS)).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `item_we`  in  1  write enable for one item-table entry.
- `item_addr`  in  AW  item index; writes with addr >= N_ITEMS are dropped.
- `item_value`, `item_weight`, `item_volume`  in  W each  entry data.
- `min_value`, `max_weight`, `max_volume`  in  W each  constraints; sampled on an accepted `start`.
- `start`  in  1  begin a search; accepted only in IDLE.
- `busy`  out  1  high while a search is in progress.
- `done`  out  1  one-cycle pulse when a search ends.
- `found`  out  1  high if the last search found a solution; held until the next accepted `start`.
- `solution`  out  N_ITEMS  winning selection, bit i = item i; 0 if none; held.
- `sol_value`, `sol_weight`, `sol_volume`  out  ACC_W each  totals of `solution`; held.

## Operation
- **Reset.** Puts the FSM in IDLE, clears the item table to all zeros, and sets every output to 0.
- **Table writes.** Accepted in IDLE and DONE only. A write while `busy` is dropped.
- **FSM states.** IDLE, SEARCH, DONE.
- **IDLE.** On `start`:
  - latch the three constraints;
  - clear the candidate register, the step counter j, and the three accumulators;
  - clear `found`, `solution` and the `sol_*` outputs;
  - go to SEARCH.
- **SEARCH.** Each cycle, compare the registered accumulators against the latched constraints: `acc_value >= min_value`, `acc_weight <= max_weight`, `acc_volume <= max_volume`. All comparisons are unsigned at ACC_W bits with the constraints zero-extended. Totals never wrap.
  - All three pass: capture the candidate and accumulators into `solution` and `sol_*`, set `found`, go to DONE.
  - Fail and j == 2^N_ITEMS - 1: go to DONE with `found` = 0.
  - Otherwise: increment j. Flip bit b = index of the lowest set bit of the new j. If that bit goes 0->1, add item b's value, weight and volume to the accumulators; if 1->0, subtract them. The candidate is therefore always gray(j) = j ^ (j >> 1).
- **DONE.** Assert `done` for exactly one cycle, then return to IDLE.
- **`start` handling.** A `start` while `busy` or in DONE is ignored.
- **`rst` mid-search.** Aborts the search with no `done` pulse; outputs return to 0.
- **Item-table stability.** The table contents are stable throughout a search because writes are blocked while `busy`.

## Timing
- `start` accepted at edge t. `busy` = 1 from cycle t+1 until DONE is left.
- Candidate j is evaluated in cycle t+1+j.
- On a match at step j: `done` is high in cycle t+2+j, and `found`, `solution` and `sol_*` are valid from that cycle.
- Exhaustion: `done` is high in cycle t+1+2^N_ITEMS with `found` = 0.
- Minimum latency: `done` at t+2 when the empty selection already passes.
- A new `start` is accepted from the cycle after `done`.

## Test plan
- **Reset.** Assert `rst` mid-search → next cycle: `busy` = `done` = `found` = 0, `solution` = 0. A following `start` searches normally.
- **First-match search.** N_ITEMS = 4; items (value, weight, volume) = (4,28,27), (8,8,27), (0,27,4), (20,18,4); min_value = 20, max_weight = max_volume = 60. Expected:
  - `done` at t+10;
  - `solution` = 4'b1100 (Gray step 8);
  - `sol_value` = 20, `sol_weight` = 45, `sol_volume` = 8.
  - Earlier candidates, e.g. 4'b0111 (value 12, weight 63), must be rejected.
- **Trivial pass.** Same table, min_value = 0 → `done` at t+2, `found` = 1, `solution` = 0, all `sol_*` = 0.
- **Infeasible.** Same table, min_value = 100 → `done` at t+17, `found` = 0, `solution` = 0.
- **No wrap.** Every item (300,300,0); min_value = 500, max_weight = 511 → `found` = 0. Two items give weight 600, which a 9-bit wrap would miscompare as 88.
- **Protocol.**
  - Pulse `start` and `item_we` (addr 0, value 50) mid-search → both ignored; search result unchanged.
  - After `done`, write addr 0, set min_value = 50, `start` → `solution` = 4'b0001 at t+3.
  - Write to addr 4 → no effect on the table.
